// File: rtl/div_arbiter.sv
// Round-robin front end that shares one sequential divider between NUM_REQ requesters.
// Zero denominators are answered locally with an all-ones quotient and never reach the divider.
module div_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_numerator,
    input  logic [NUM_REQ*WIDTH-1:0] req_denominator,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]         resp_quotient,
    output logic                     busy,
    output logic                     div_start,
    output logic [WIDTH-1:0]         div_numerator,
    output logic [WIDTH-1:0]         div_denominator,
    input  logic [WIDTH-1:0]         div_quotient,
    input  logic                     div_finished
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] gnt_id;

    logic            gnt_found;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W:0]   cand;
    logic [WIDTH-1:0] sel_num;
    logic [WIDTH-1:0] sel_den;
    logic [ID_W-1:0] rr_ptr_next;

    // Round-robin search: first pending requester at or above rr_ptr, wrapping
    // modulo NUM_REQ (which need not be a power of two, hence the extra bit).
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!gnt_found && req_valid[cand[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        sel_num = '0;
        sel_den = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                sel_num = req_numerator[i*WIDTH +: WIDTH];
                sel_den = req_denominator[i*WIDTH +: WIDTH];
            end
        end
    end

    assign rr_ptr_next = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);

    // Next-state logic. A finished seen during ISSUE may be left over from the
    // previous operation, so only WAIT looks at it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (gnt_found) state_next = (sel_den == '0) ? RESP : ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (div_finished) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE && gnt_found) ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign busy      = (state != IDLE);

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: this block holds only a handful of control/data flops and no
    // memories, so every one of them is reset; an abandoned divide leaves no trace.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr          <= '0;
            gnt_id          <= '0;
            div_start       <= 1'b0;
            div_numerator   <= '0;
            div_denominator <= '0;
            resp_valid      <= '0;
            resp_quotient   <= '0;
        end else begin
            div_start  <= 1'b0;
            resp_valid <= '0;
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        div_numerator   <= sel_num;
                        div_denominator <= sel_den;
                        gnt_id          <= gnt_idx;
                        rr_ptr          <= rr_ptr_next;
                        if (sel_den == '0) begin
                            resp_quotient <= '1;
                            resp_valid    <= NUM_REQ'(1) << gnt_idx;
                        end else begin
                            div_start <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (div_finished) begin
                        resp_quotient <= div_quotient;
                        resp_valid    <= NUM_REQ'(1) << gnt_id;
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
    a_resp_onehot:  assert property (@(posedge clk) disable iff (rst) $onehot0(resp_valid));
    a_start_issue:  assert property (@(posedge clk) disable iff (rst) div_start |-> state == ISSUE);
`endif

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter: a behavioural divider with adjustable latency and
// pulse or hold-until-next-start finished, per-requester operand queues and logs.
module tb_div_arbiter;

    localparam int WIDTH   = 32;
    localparam int NUM_REQ = 4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_numerator;
    logic [NUM_REQ*WIDTH-1:0] req_denominator;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [WIDTH-1:0]         resp_quotient;
    logic                     busy;
    logic                     div_start;
    logic [WIDTH-1:0]         div_numerator;
    logic [WIDTH-1:0]         div_denominator;
    logic [WIDTH-1:0]         div_quotient;
    logic                     div_finished;

    div_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_numerator   (req_numerator),
        .req_denominator (req_denominator),
        .req_ready       (req_ready),
        .resp_valid      (resp_valid),
        .resp_quotient   (resp_quotient),
        .busy            (busy),
        .div_start       (div_start),
        .div_numerator   (div_numerator),
        .div_denominator (div_denominator),
        .div_quotient    (div_quotient),
        .div_finished    (div_finished)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Divider model: finished rises lat+1 cycles after start; in hold mode it
    // stays high (with the old quotient) until the next start.
    int   lat       = 1;
    bit   hold_mode = 1'b0;
    int   m_cnt;
    logic m_run;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run        <= 1'b0;
            m_cnt        <= 0;
            div_finished <= 1'b0;
            div_quotient <= '0;
        end else if (div_start) begin
            m_run        <= 1'b1;
            m_cnt        <= lat;
            div_finished <= 1'b0;
            div_quotient <= (div_denominator != 0) ? div_numerator / div_denominator : '1;
        end else if (m_run) begin
            if (m_cnt <= 1) begin
                m_run        <= 1'b0;
                div_finished <= 1'b1;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (!hold_mode) begin
            div_finished <= 1'b0;
        end
    end

    // Per-requester operand queues; indices only grow so no process clears another's state.
    logic [WIDTH-1:0] qn[NUM_REQ][32];
    logic [WIDTH-1:0] qd[NUM_REQ][32];
    int head[NUM_REQ];
    int tail[NUM_REQ];

    task automatic push(input int r, input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d);
        qn[r][tail[r]] = n;
        qd[r][tail[r]] = d;
        tail[r]++;
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        req_valid       = '0;
        req_numerator   = '0;
        req_denominator = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (head[i] < tail[i]) begin
                    req_valid[i] = 1'b1;
                    req_numerator[i*WIDTH +: WIDTH]   = qn[i][head[i]];
                    req_denominator[i*WIDTH +: WIDTH] = qd[i][head[i]];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: logs grants, starts and responses mid-cycle.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int               gnt_q[$];
    logic [NUM_REQ-1:0] rv_q[$];
    logic [WIDTH-1:0] rq_q[$];
    int   acc_cyc    = 0;
    int   start_cyc  = 0;
    int   resp_cyc   = 0;
    int   start_cnt  = 0;
    int   multihot   = 0;
    logic busy_after = 1'b1;
    logic prev_resp  = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if ($countones(req_ready) > 1) multihot++;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) begin
                    gnt_q.push_back(i);
                    head[i]++;
                    acc_cyc = cyc;
                end
            end
            if (div_start) begin
                start_cnt++;
                start_cyc = cyc;
            end
            if (prev_resp) busy_after = busy;
            prev_resp = |resp_valid;
            if (|resp_valid) begin
                rv_q.push_back(resp_valid);
                rq_q.push_back(resp_quotient);
                resp_cyc = cyc;
            end
        end
    end

    function automatic int gnt_at(input int k);
        return (k < gnt_q.size()) ? gnt_q[k] : -1;
    endfunction
    function automatic logic [NUM_REQ-1:0] rv_at(input int k);
        return (k < rv_q.size()) ? rv_q[k] : 'x;
    endfunction
    function automatic logic [WIDTH-1:0] rq_at(input int k);
        return (k < rq_q.size()) ? rq_q[k] : 'x;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_resps(input string tag, input int base, input int n);
        for (int c = 0; c < 400 && (rv_q.size() - base) < n; c++) @(posedge clk);
        #1;
        check(tag, 64'(rv_q.size() - base), 64'(n));
    endtask

    int gb, rb, sb, mb;

    initial begin
        // 1: single op, latency and idle-after-response
        lat = 3; hold_mode = 1'b0;
        do_reset();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_resp_valid", 64'(resp_valid), 64'(0));
        check("rst_div_start", 64'(div_start), 64'(0));
        gb = gnt_q.size(); rb = rv_q.size(); sb = start_cnt;
        push(1, 100, 7);
        wait_resps("t1_done", rb, 1);
        repeat (2) @(posedge clk);
        #1;
        check("t1_grant", 64'(gnt_at(gb)), 64'(1));
        check("t1_start_lat", 64'(start_cyc - acc_cyc), 64'(1));
        check("t1_resp_lat", 64'(resp_cyc - acc_cyc), 64'(6));
        check("t1_resp_valid", 64'(rv_at(rb)), 64'(4'b0010));
        check("t1_quotient", 64'(rq_at(rb)), 64'(14));
        check("t1_busy_after", 64'(busy_after), 64'(0));
        check("t1_starts", 64'(start_cnt - sb), 64'(1));

        // 2: contention, then wrap-around from rr_ptr=3
        lat = 1;
        do_reset();
        gb = gnt_q.size(); rb = rv_q.size();
        push(0, 100, 10);
        push(2, 77, 7);
        wait_resps("t2a_done", rb, 2);
        push(3, 1000, 8);
        push(0, 45, 5);
        wait_resps("t2b_done", rb, 4);
        check("t2_grant0", 64'(gnt_at(gb)), 64'(0));
        check("t2_grant1", 64'(gnt_at(gb+1)), 64'(2));
        check("t2_grant2", 64'(gnt_at(gb+2)), 64'(3));
        check("t2_grant3", 64'(gnt_at(gb+3)), 64'(0));
        check("t2_rv0", 64'(rv_at(rb)), 64'(4'b0001));
        check("t2_rv1", 64'(rv_at(rb+1)), 64'(4'b0100));
        check("t2_rv2", 64'(rv_at(rb+2)), 64'(4'b1000));
        check("t2_rv3", 64'(rv_at(rb+3)), 64'(4'b0001));
        check("t2_q0", 64'(rq_at(rb)), 64'(10));
        check("t2_q1", 64'(rq_at(rb+1)), 64'(11));
        check("t2_q2", 64'(rq_at(rb+2)), 64'(125));
        check("t2_q3", 64'(rq_at(rb+3)), 64'(9));

        // 3: fairness with all four requesters busy for eight ops
        lat = 2;
        do_reset();
        gb = gnt_q.size(); rb = rv_q.size(); mb = multihot;
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < NUM_REQ; i++) push(i, 32'((i+1)*(j+3)), 32'(i+1));
        end
        wait_resps("t3_done", rb, 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t3_grant%0d", k), 64'(gnt_at(gb+k)), 64'(k % 4));
            check($sformatf("t3_rv%0d", k), 64'(rv_at(rb+k)), 64'(1 << (k % 4)));
            check($sformatf("t3_q%0d", k), 64'(rq_at(rb+k)), 64'(k/4 + 3));
        end
        check("t3_multihot", 64'(multihot - mb), 64'(0));

        // 4: divide by zero handled locally
        do_reset();
        rb = rv_q.size(); sb = start_cnt;
        push(3, 5, 0);
        wait_resps("t4_done", rb, 1);
        repeat (3) @(posedge clk);
        #1;
        check("t4_resp_lat", 64'(resp_cyc - acc_cyc), 64'(1));
        check("t4_rv", 64'(rv_at(rb)), 64'(4'b1000));
        check("t4_q", 64'(rq_at(rb)), 64'(32'hFFFF_FFFF));
        check("t4_no_start", 64'(start_cnt - sb), 64'(0));

        // 5: reset during WAIT abandons the divide; rr_ptr restarts at 0
        lat = 6;
        do_reset();
        rb = rv_q.size(); sb = start_cnt;
        push(2, 600, 6);
        for (int c = 0; c < 50 && start_cnt == sb; c++) @(posedge clk);
        check("t5_started", 64'(start_cnt - sb), 64'(1));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t5_rst_busy", 64'(busy), 64'(0));
        check("t5_rst_ready", 64'(req_ready), 64'(0));
        check("t5_rst_resp_valid", 64'(resp_valid), 64'(0));
        check("t5_rst_quotient", 64'(resp_quotient), 64'(0));
        check("t5_rst_div_start", 64'(div_start), 64'(0));
        check("t5_rst_div_num", 64'(div_numerator), 64'(0));
        check("t5_rst_div_den", 64'(div_denominator), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("t5_no_resp", 64'(rv_q.size() - rb), 64'(0));
        gb = gnt_q.size();
        push(1, 9, 3);
        push(3, 8, 2);
        wait_resps("t5_done", rb, 2);
        check("t5_grant0", 64'(gnt_at(gb)), 64'(1));
        check("t5_grant1", 64'(gnt_at(gb+1)), 64'(3));
        check("t5_q0", 64'(rq_at(rb)), 64'(3));
        check("t5_q1", 64'(rq_at(rb+1)), 64'(4));

        // 6: finished held high until the next start must not be captured early
        lat = 2; hold_mode = 1'b1;
        do_reset();
        rb = rv_q.size(); sb = start_cnt;
        push(0, 50, 5);
        push(0, 81, 9);
        wait_resps("t6_done", rb, 2);
        check("t6_q0", 64'(rq_at(rb)), 64'(10));
        check("t6_q1", 64'(rq_at(rb+1)), 64'(9));
        check("t6_rv1", 64'(rv_at(rb+1)), 64'(4'b0001));
        check("t6_starts", 64'(start_cnt - sb), 64'(2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares one `divider` instance between NUM_REQ requesters, e.g. shader lanes or rasterizer units.
- Round-robin arbitration; one outstanding divide at a time.
- Latches the granted operands, sequences the divider's start/finished handshake, and returns the quotient to the granted requester.
- Handles divide-by-zero locally, without using the divider.

Parameters:
- WIDTH, 32, operand/quotient width; must match the attached divider's WIDTH.
- NUM_REQ, 4, number of requesters, >=2, need not be a power of 2.
- ID_W, $clog2(NUM_REQ), localparam, width of requester index.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset. The parent drives the divider's rst_n from ~rst.
- req_valid  in  NUM_REQ  per-requester request. Held high, with operands stable, until that requester's req_ready is seen.
- req_numerator  in  NUM_REQ*WIDTH  packed numerators; requester i occupies [i*WIDTH +: WIDTH].
- req_denominator  in  NUM_REQ*WIDTH  packed denominators, same packing.
- req_ready  out  NUM_REQ  one-hot accept strobe, combinational, high only in IDLE.
- resp_valid  out  NUM_REQ  one-hot, registered, one-cycle result strobe. There is no backpressure.
- resp_quotient  out  WIDTH  registered result, valid while any resp_valid bit is high.
- busy  out  1  high in every state except IDLE.
- div_start  out  1  registered one-cycle start pulse to the divider.
- div_numerator  out  WIDTH  latched numerator, held stable from ISSUE through WAIT.
- div_denominator  out  WIDTH  latched denominator, held stable from ISSUE through WAIT.
- div_quotient  in  WIDTH  divider result.
- div_finished  in  1  divider done indication, level or pulse.

Behaviour:
- Reset values: all registered outputs are 0, namely resp_valid, resp_quotient, div_start, div_numerator, div_denominator. Also state=IDLE and rr_ptr=0.
- Reset is asynchronous. Asserting it mid-operation abandons the in-flight divide; no response is ever produced for it.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, grant g = first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - req_ready[g]=1 in that cycle. At the clock edge: latch operands, store g, and set rr_ptr = (g+1) mod NUM_REQ.
  - If the latched denominator is 0: next state RESP, quotient {WIDTH{1'b1}}, div_start is never pulsed.
  - Otherwise: next state ISSUE.
  - No request pending: stay in IDLE; rr_ptr is unchanged.
- ISSUE:
  - div_start=1 for exactly this cycle.
  - div_finished is ignored in this cycle, because a stale finished from the previous op may still be asserted.
  - Next state: WAIT.
- WAIT:
  - div_start=0. Operand outputs are held.
  - On the first cycle div_finished=1: capture div_quotient into resp_quotient and go to RESP.
  - There is no timeout.
- RESP:
  - resp_valid[g]=1 for one cycle, resp_quotient valid.
  - Next state: IDLE. A new grant can therefore occur the cycle after RESP.
- Latency, with accept at cycle T and divider latency L (div_start to div_finished):
  - div_start at T+1.
  - resp_valid at T+2+L.
  - Zero-denominator path: resp_valid at T+1.
- Throughput: one op per (L+3) cycles.
- req_ready is only ever asserted in IDLE and is never multi-hot.
- A requester dropping req_valid before it is accepted is legal; it is simply not granted.
- Simultaneous request and grant: only the granted requester is accepted. The others stay pending and are served in round-robin order.
- Wrap-around: with rr_ptr = NUM_REQ-1 and requests at NUM_REQ-1 and 0, grant NUM_REQ-1 first, then 0.
- Arithmetic: the quotient passes through from the divider unmodified. Numerator and denominator are unsigned.

Test Plan:
1. Single op: req_valid[1], num=100, den=7 -> req_ready[1] for one cycle, div_start one cycle later; after div_finished, resp_valid=4'b0010 with quotient=14, busy low the cycle after.
2. Contention: req_valid[0] and req_valid[2] both held high from reset -> grants 0 then 2, and resp_valid order 0001 then 0100. Then raise req 0 and 3 with rr_ptr=3 -> grant 3 first.
3. Fairness: all four requesters held high for 8 ops -> grant order 0,1,2,3,0,1,2,3; no req_ready is ever multi-hot.
4. Divide by zero: req 3, num=5, den=0 -> resp_valid[3] one cycle after accept, quotient 0xFFFFFFFF, div_start never asserted.
5. Reset mid-op: assert rst during WAIT -> all outputs 0 immediately; the pending finished produces no resp_valid. The next request (num=9, den=3) is granted from rr_ptr=0 and returns 3.
6. Stale finished: divider holds finished high until the next start; issue back-to-back ops 50/5 then 81/9 -> results 10 then 9, and the second result is never captured early.
